// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core front end: fetch FSM states,
// instruction-memory geometry and the default halt opcode.
package cpu_pkg;

  localparam int         IMEM_DEPTH_DEF  = 64;
  localparam int         IMEM_ADDR_W     = $clog2(IMEM_DEPTH_DEF);
  localparam int         INSTR_W         = 8;
  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } ifetch_state_t;

  // Reduce an 8-bit address modulo a power-of-two memory depth.
  function automatic logic [7:0] pc_wrap(input logic [7:0] addr, input logic [7:0] mask);
    return addr & mask;
  endfunction

endpackage

// File: rtl/ifetch_pc.sv
// Program counter for instruction_fetch: redirect load, wrapping increment,
// and hold when neither is requested.
module ifetch_pc
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       redirect,
  input  logic [7:0] target,
  input  logic       advance,
  output logic [7:0] pc
);

  localparam logic [7:0] PC_MASK = 8'(IMEM_DEPTH - 1);

  logic [7:0] pc_d;
  logic [7:0] pc_q;

  // Next-PC selection; redirect beats advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = pc_wrap(target, PC_MASK);
    end else if (advance) begin
      pc_d = pc_wrap(pc_q + 8'd1, PC_MASK);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 8'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC to instruction_mem and registers the returned word
// for decode with a valid/ready handshake. Optional halt-on-opcode: IFETCH_HALT_EN.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int         IMEM_DEPTH  = IMEM_DEPTH_DEF,
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       instruction_address,
  input  logic [7:0]       instruction_data,
  input  logic             branch_taken,
  input  logic [7:0]       branch_target,
  output logic             fetch_valid,
  output logic [7:0]       fetch_instruction,
  output logic [7:0]       fetch_pc,
  input  logic             decode_ready,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

`ifdef IFETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  ifetch_state_t    state_d, state_q;
  logic             fetch_valid_d, fetch_valid_q;
  logic [7:0]       fetch_instruction_d, fetch_instruction_q;
  logic [7:0]       fetch_pc_d, fetch_pc_q;
  logic             halted_d, halted_q;
  logic [CNT_W-1:0] fetch_count_d, fetch_count_q;

  logic [7:0] pc_s;
  logic       accept_s;
  logic       load_s;
  logic       halt_load_s;

  assign accept_s    = fetch_valid_q & decode_ready;
  assign load_s      = (state_q == FETCH) & (~fetch_valid_q | decode_ready) & ~branch_taken;
  assign halt_load_s = HALT_EN & load_s & (instruction_data == HALT_OPCODE);

  ifetch_pc #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .redirect(branch_taken),
    .target  (branch_target),
    .advance (load_s),
    .pc      (pc_s)
  );

  // Fetch FSM next state; a redirect never changes state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
        else       state_d = IDLE;
      end
      FETCH: begin
        if (halt_load_s) state_d = HALT;
        else             state_d = FETCH;
      end
      HALT: begin
        if (start) state_d = FETCH;
        else       state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage and delivered-instruction counter.
  always_comb begin
    fetch_valid_d       = fetch_valid_q;
    fetch_instruction_d = fetch_instruction_q;
    fetch_pc_d          = fetch_pc_q;
    fetch_count_d       = fetch_count_q;
    halted_d            = (state_d == HALT);
    if (branch_taken) begin
      fetch_valid_d = 1'b0;
    end else if (load_s) begin
      fetch_valid_d       = 1'b1;
      fetch_instruction_d = instruction_data;
      fetch_pc_d          = pc_s;
    end else if (accept_s) begin
      fetch_valid_d = 1'b0;
    end else begin
      fetch_valid_d = fetch_valid_q;
    end
    // An accept counts even when a redirect flushes the stage on the same edge.
    if (accept_s && (fetch_count_q != {CNT_W{1'b1}})) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      fetch_valid_q       <= 1'b0;
      fetch_instruction_q <= 8'd0;
      fetch_pc_q          <= 8'd0;
      halted_q            <= 1'b0;
      fetch_count_q       <= {CNT_W{1'b0}};
    end else begin
      state_q             <= state_d;
      fetch_valid_q       <= fetch_valid_d;
      fetch_instruction_q <= fetch_instruction_d;
      fetch_pc_q          <= fetch_pc_d;
      halted_q            <= halted_d;
      fetch_count_q       <= fetch_count_d;
    end
  end

  assign instruction_address = pc_s;
  assign fetch_valid         = fetch_valid_q;
  assign fetch_instruction   = fetch_instruction_q;
  assign fetch_pc            = fetch_pc_q;
  assign halted              = HALT_EN & halted_q;
  assign fetch_count         = fetch_count_q;

endmodule
